// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with shadow E/M/W state, stall/flush/forward logic and stall counter.
module hazard_ctrl (
    input  logic        CLK,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  WriteRegD,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        BranchD,
    input  logic        JumpRegD,
    input  logic        PCSrcD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [15:0] StallCnt
);
    logic [4:0]  rs_e_q, rt_e_q, wr_e_q, wr_m_q, wr_w_q;
    logic [4:0]  rs_e_d, rt_e_d, wr_e_d, wr_m_d, wr_w_d;
    logic        rw_e_q, mtr_e_q, rw_m_q, mtr_m_q, rw_w_q;
    logic        rw_e_d, mtr_e_d, rw_m_d, mtr_m_d, rw_w_d;
    logic [15:0] cnt_q, cnt_d;
    logic        e_rs, e_rt, m_rs, m_rt, lwstall, branchstall, stall;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic hit(input logic [4:0] src, input logic [4:0] wr, input logic rw);
        return rw && src != 5'd0 && src == wr;
    endfunction

    assign e_rs        = hit(RsD, wr_e_q, rw_e_q);
    assign e_rt        = hit(RtD, wr_e_q, rw_e_q);
    assign m_rs        = hit(RsD, wr_m_q, rw_m_q);
    assign m_rt        = hit(RtD, wr_m_q, rw_m_q);
    assign lwstall     = mtr_e_q && (e_rs || e_rt);
    assign branchstall = (BranchD && (e_rs || e_rt || (mtr_m_q && (m_rs || m_rt))))
                      || (JumpRegD && (e_rs || (mtr_m_q && m_rs)));
    assign stall       = lwstall || branchstall;

    assign StallF    = stall;
    assign StallD    = stall;
    assign FlushE    = stall;
    assign FlushD    = (PCSrcD || JumpRegD) && !stall;
    assign ForwardAD = m_rs;
    assign ForwardBD = m_rt;
    assign ForwardAE = hit(rs_e_q, wr_m_q, rw_m_q) ? 2'b10 : hit(rs_e_q, wr_w_q, rw_w_q) ? 2'b01 : 2'b00;
    assign ForwardBE = hit(rt_e_q, wr_m_q, rw_m_q) ? 2'b10 : hit(rt_e_q, wr_w_q, rw_w_q) ? 2'b01 : 2'b00;
    assign StallCnt  = cnt_q;

    always_comb begin
        rs_e_d  = stall ? 5'd0 : RsD;
        rt_e_d  = stall ? 5'd0 : RtD;
        wr_e_d  = stall ? 5'd0 : WriteRegD;
        rw_e_d  = stall ? 1'b0 : RegWriteD;
        mtr_e_d = stall ? 1'b0 : MemtoRegD;
        wr_m_d  = wr_e_q;
        rw_m_d  = rw_e_q;
        mtr_m_d = mtr_e_q;
        wr_w_d  = wr_m_q;
        rw_w_d  = rw_m_q;
        cnt_d   = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rs_e_q  <= 5'd0;
            rt_e_q  <= 5'd0;
            wr_e_q  <= 5'd0;
            rw_e_q  <= 1'b0;
            mtr_e_q <= 1'b0;
            wr_m_q  <= 5'd0;
            rw_m_q  <= 1'b0;
            mtr_m_q <= 1'b0;
            wr_w_q  <= 5'd0;
            rw_w_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            rs_e_q  <= rs_e_d;
            rt_e_q  <= rt_e_d;
            wr_e_q  <= wr_e_d;
            rw_e_q  <= rw_e_d;
            mtr_e_q <= mtr_e_d;
            wr_m_q  <= wr_m_d;
            rw_m_q  <= rw_m_d;
            mtr_m_q <= mtr_m_d;
            wr_w_q  <= wr_w_d;
            rw_w_q  <= rw_w_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 CLK  in  1  clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 RsD, RtD  in  5 each  source register fields of the decode-stage instruction.
REQ-005 WriteRegD  in  5  decode-stage destination: rd when RegDstD=1, else rt.
REQ-006 RegWriteD, MemtoRegD, BranchD, JumpRegD  in  1 each  decode-stage control flags.
REQ-007 PCSrcD  in  1  decode-stage taken-branch indication.
REQ-008 StallF, StallD  out  1 each  hold the PC and the IF/ID register.
REQ-009 FlushD, FlushE  out  1 each  clear the IF/ID register and the ID/EX register (bubble).
REQ-010 ForwardAD, ForwardBD  out  1 each  select ALUOutM for the decode-stage compare operands.
REQ-011 ForwardAE, ForwardBE  out  2 each  execute-operand select: 00 register file, 01 ResultW, 10 ALUOutM.
REQ-012 StallCnt  out  16  saturating count of decode-stall cycles.

Function
REQ-013 The block SHALL keep shadow pipeline registers E, M and W, each holding WriteReg, RegWrite and MemtoReg; E additionally holds Rs and Rt.
REQ-014 E update:
- FlushE=1: E SHALL load all-zero (bubble).
- Otherwise: E SHALL load RsD, RtD, WriteRegD, RegWriteD and MemtoRegD.
REQ-015 M SHALL load E and W SHALL load M every cycle, unconditionally.
REQ-016 Match rule: a source matches a stage only if the source is nonzero, equals that stage's WriteReg, and that stage's RegWrite=1; register 0 SHALL never match.
REQ-017 lwstall SHALL be 1 when MemtoRegE=1 and E matches RsD or RtD.
REQ-018 branchstall SHALL be 1 when either condition holds:
- BranchD=1 and (E matches RsD or RtD, or (MemtoRegM=1 and M matches RsD or RtD)).
- JumpRegD=1 and (E matches RsD, or (MemtoRegM=1 and M matches RsD)); RtD SHALL be ignored for jr.
REQ-019 Stall outputs: StallF = StallD = FlushE = lwstall OR branchstall, combinational from current state and inputs.
REQ-020 FlushD SHALL be (PCSrcD OR JumpRegD) AND NOT StallD.
REQ-021 ForwardAD SHALL be 1 when M matches RsD; ForwardBD SHALL be 1 when M matches RtD.
REQ-022 ForwardAE priority: 10 if M matches RsE; else 01 if W matches RsE; else 00. ForwardBE SHALL apply the same rule to RtE.
REQ-023 StallCnt SHALL increment by 1 on each clock edge where StallD=1, and SHALL hold at 0xFFFF once reached (no wrap).
REQ-024 Latency:
- All stall, flush and forward outputs SHALL be combinational from shadow state plus decode inputs (zero-cycle).
- StallCnt SHALL reflect a stall one cycle after it is asserted.
REQ-025 Under simultaneous lwstall and branchstall, the block SHALL produce the single-stall outputs once; StallCnt SHALL increment once per cycle.
REQ-026 During consecutive stall cycles, the same decode inputs SHALL be re-evaluated each cycle, and the stall SHALL clear once the blocking producer has advanced past the checked stage.

Reset
REQ-027 When reset=1 at a clock edge, all shadow registers SHALL clear to 0 and StallCnt SHALL clear to 0, overriding any stall or flush in the same cycle.
REQ-028 After reset, with all-zero decode inputs, every output SHALL be 0.
REQ-029 Reset asserted mid-stall SHALL drop StallF, StallD and FlushE on the following cycle unless the decode inputs re-create a hazard against the cleared state; none can exist immediately after reset, because the shadow state is all zero.

Verification
REQ-030 The bench SHALL cover these scenarios:
- lw-use: lw $2 (WriteRegD=2, MemtoRegD=1, RegWriteD=1), then add with RsD=2 -> StallF=StallD=FlushE=1 for 1 cycle, then ForwardAE=01; StallCnt=1.
- ALU forwarding: add $3, then sub with RtD=3 -> no stall; ForwardBE=10 in the first cycle; with one instruction between them, ForwardBE=01.
- beq after lw: lw $4, then beq RsD=4 -> 2 stall cycles, then ForwardAD=0 (data arrives via the register file); with PCSrcD=1 afterward, FlushD=1 only after the stall clears.
- jr after add $31: jr RsD=31 -> 1 stall cycle, then ForwardAD=1; with RtD=31 and RsD=5 -> no stall.
- $0 writer: add with WriteRegD=0, then consumer RsD=0 -> no stall and ForwardAE=00.
- Saturation and reset: force 70000 consecutive stall cycles -> StallCnt=0xFFFF and holds; pulse reset during a stall -> StallCnt=0 and stalls drop on the next cycle.
